audio_level_meter: RTL and testbench

//  Parametrised successor to the fixed 16-step mic volume indicator. Takes Audio_Capture samples and finds the
//  per-window peak, then quantises it to LEVELS steps. Optional peak-hold with timed decay. Drives the LED bar
//  and a 2-digit multiplexed 7-seg readout. Sits between Audio_Capture and the OLED/game logic, which consume `level`.

---
 rtl/audio_level_meter_pkg.sv | 63 ++++++
 rtl/seven_seg_scan2.sv | 68 ++++++
 rtl/audio_level_meter.sv | 165 ++++++++++++++++
 tb/tb_audio_level_meter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_level_meter_pkg.sv
// audio_level_meter_pkg
//   Shared constants and helpers for the audio level meter slice.
//   - SEG_0..SEG_9, SEG_BLANK : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - AN_OFF                  : value driven on the two unused digit enables an[3:2]
//   - slot_e                  : which multiplexed digit is currently being driven
//   - clog2 / width_of        : elaboration-time width helpers (width_of never returns 0)
//   - seg_decode              : BCD digit to active-low segment pattern
package audio_level_meter_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] AN_OFF = 2'b11;

  typedef enum logic {
    SLOT_UNITS = 1'b0,
    SLOT_TENS  = 1'b1
  } slot_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Register width for a counter that must hold 0..v-1; at least one bit.
  function automatic int width_of(input int v);
    int w;
    w = clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scan2.sv
// seven_seg_scan2
//   Two-digit multiplexed driver for a common-anode 7-segment display.
//   A refresh counter counts CLK cycles; each time it wraps at REFRESH_DIV-1
//   the active slot flips between the units digit and the tens digit.
// Ports
//   CLK        in   1   system clock
//   reset      in   1   synchronous, active-high; returns to the units slot
//   tens       in   4   BCD tens digit
//   units      in   4   BCD units digit
//   tens_blank in   1   1: tens digit dark (segments off, enable still driven)
//   seg        out  7   active-low segments {g..a}
//   an         out  4   active-low digit enables; an[3:2] always off
// The slot state is directly visible on an[1:0] (10 = units, 01 = tens).
module seven_seg_scan2
  import audio_level_meter_pkg::*;
#(
  parameter int REFRESH_DIV = 131232
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       tens_blank,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int RW = width_of(REFRESH_DIV);

  logic [RW-1:0] refresh_cnt;
  logic          wrap;
  slot_e         slot_q;
  slot_e         slot_d;

  assign wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge CLK) begin
    if (reset) begin
      refresh_cnt <= '0;
      slot_q      <= SLOT_UNITS;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
      slot_q      <= slot_d;
    end
  end

  // Next slot plus the digit mux; outputs are a pure decode of the slot
  // register and the incoming digits so they follow those with no extra delay.
  always_comb begin
    slot_d = slot_q;
    an     = {AN_OFF, 2'b10};
    seg    = seg_decode(units);
    if (wrap) begin
      slot_d = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
    end
    case (slot_q)
      SLOT_TENS: begin
        an  = {AN_OFF, 2'b01};
        seg = tens_blank ? SEG_BLANK : seg_decode(tens);
      end
      default: begin
        an  = {AN_OFF, 2'b10};
        seg = seg_decode(units);
      end
    endcase
  end

endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter
//   Finds the peak microphone sample over each window of WINDOW accepted
//   samples, quantises it to one of LEVELS steps, keeps a decaying peak-hold
//   level, and drives a thermometer LED bar plus a two-digit 7-seg readout.
// Ports
//   CLK          in   1         system clock
//   reset        in   1         synchronous, active-high; wins over all inputs
//   sample_valid in   1         one-cycle strobe, `sample` is new
//   sample       in   SAMPLE_W  unsigned mic sample
//   hold_en      in   1         1: LEDs/readout show hold_level, 0: show level
//   level        out  LW        level of the last completed window
//   level_valid  out  1         one-cycle pulse when `level` updates
//   hold_level   out  LW        peak-hold level
//   led          out  LEVELS    thermometer, bits [shown:0] set
//   seg          out  7         active-low segments {g..a}
//   an           out  4         active-low digit enables
//   dp           out  1         decimal point, always off
// Handshake: sample_valid is a push-only strobe with no back-pressure; the
// meter accepts a sample on every cycle sample_valid is high and nothing
// happens on cycles where it is low. level_valid is likewise a push-only
// pulse, aligned with the cycle in which `level` first shows the new value.
module audio_level_meter
  import audio_level_meter_pkg::*;
#(
  parameter  int SAMPLE_W     = 12,
  parameter  int LEVELS       = 16,
  parameter  int OFFSET       = 2048,
  parameter  int STEP_SHIFT   = 7,
  parameter  int WINDOW       = 10000,
  parameter  int HOLD_WINDOWS = 4,
  parameter  int REFRESH_DIV  = 131232,
  localparam int LW           = clog2(LEVELS)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                hold_en,
  output logic [LW-1:0]       level,
  output logic                level_valid,
  output logic [LW-1:0]       hold_level,
  output logic [LEVELS-1:0]   led,
  output logic [6:0]          seg,
  output logic [3:0]          an,
  output logic                dp
);

  localparam int WCW = width_of(WINDOW);
  localparam int HCW = width_of(HOLD_WINDOWS);

  // Window accumulation
  logic [WCW-1:0]      win_cnt;
  logic [SAMPLE_W-1:0] win_max;
  logic [SAMPLE_W-1:0] peak;
  logic                window_end;

  // Quantiser
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] q;
  logic [LW-1:0]       new_level;

  // Peak hold
  logic [HCW-1:0]      hold_cnt;
  logic [LW-1:0]       hold_d;
  logic [HCW-1:0]      hold_cnt_d;

  // Display path
  logic [LW-1:0]       shown;
  logic [6:0]          bcd_rem;
  logic [3:0]          tens;
  logic [3:0]          units;
  logic                tens_blank;

  // Peak includes the sample arriving this cycle, so the final strobe of a
  // window contributes to that window's level.
  assign peak       = (sample > win_max) ? sample : win_max;
  assign window_end = sample_valid && (win_cnt == WCW'(WINDOW - 1));

  always_comb begin
    amp       = (peak > SAMPLE_W'(OFFSET)) ? peak - SAMPLE_W'(OFFSET) : '0;
    q         = amp >> STEP_SHIFT;
    new_level = (q > SAMPLE_W'(LEVELS - 1)) ? LW'(LEVELS - 1) : LW'(q);
  end

  // Peak-hold next state. Only committed on window-end cycles. The decay
  // floor is the new level so the held value never undershoots live audio.
  always_comb begin
    hold_d     = hold_level;
    hold_cnt_d = hold_cnt;
    if (new_level >= hold_level) begin
      hold_d     = new_level;
      hold_cnt_d = '0;
    end else if (hold_cnt == HCW'(HOLD_WINDOWS - 1)) begin
      hold_d     = ((hold_level - LW'(1)) > new_level) ? hold_level - LW'(1) : new_level;
      hold_cnt_d = '0;
    end else begin
      hold_cnt_d = hold_cnt + HCW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      win_cnt     <= '0;
      win_max     <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      hold_level  <= '0;
      hold_cnt    <= '0;
      shown       <= '0;
    end else begin
      level_valid <= 1'b0;
      if (sample_valid) begin
        if (window_end) begin
          win_cnt     <= '0;
          win_max     <= '0;
          level       <= new_level;
          level_valid <= 1'b1;
          hold_level  <= hold_d;
          hold_cnt    <= hold_cnt_d;
        end else begin
          win_cnt <= win_cnt + WCW'(1);
          win_max <= peak;
        end
      end
      shown <= hold_en ? hold_level : level;
    end
  end

  // Binary to BCD by repeated compare/subtract of ten; LEVELS <= 99 means
  // at most nine subtractions are ever needed.
  always_comb begin
    bcd_rem = 7'(shown);
    tens    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (bcd_rem >= 7'd10) begin
        bcd_rem = bcd_rem - 7'd10;
        tens    = tens + 4'd1;
      end
    end
    units      = bcd_rem[3:0];
    tens_blank = (tens == 4'd0);
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < LEVELS; i++) begin
      led[i] = (i <= int'(shown));
    end
  end

  assign dp = 1'b1;

  seven_seg_scan2 #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .CLK        (CLK),
    .reset      (reset),
    .tens       (tens),
    .units      (units),
    .tens_blank (tens_blank),
    .seg        (seg),
    .an         (an)
  );

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

  localparam int SAMPLE_W     = 12;
  localparam int LEVELS       = 16;
  localparam int LW           = 4;
  localparam int WINDOW       = 8;
  localparam int HOLD_WINDOWS = 2;
  localparam int REFRESH_DIV  = 16;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                hold_en;
  logic [LW-1:0]       level;
  logic                level_valid;
  logic [LW-1:0]       hold_level;
  logic [LEVELS-1:0]   led;
  logic [6:0]          seg;
  logic [3:0]          an;
  logic                dp;

  always #5 clk = ~clk;

  audio_level_meter #(
    .SAMPLE_W     (SAMPLE_W),
    .LEVELS       (LEVELS),
    .OFFSET       (2048),
    .STEP_SHIFT   (7),
    .WINDOW       (WINDOW),
    .HOLD_WINDOWS (HOLD_WINDOWS),
    .REFRESH_DIV  (REFRESH_DIV)
  ) dut (
    .CLK          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .hold_en      (hold_en),
    .level        (level),
    .level_valid  (level_valid),
    .hold_level   (hold_level),
    .led          (led),
    .seg          (seg),
    .an           (an),
    .dp           (dp)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_hold_q[$];
  int m_cnt;
  int m_max;
  int m_hold;
  int m_hold_cnt;

  function automatic int quant(input int pk);
    int lv;
    if (pk <= 2048) return 0;
    lv = (pk - 2048) / 128;
    return (lv > LEVELS - 1) ? LEVELS - 1 : lv;
  endfunction

  function automatic logic [LEVELS-1:0] therm(input int n);
    logic [LEVELS-1:0] r;
    r = '0;
    for (int i = 0; i <= n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt      = 0;
    m_max      = 0;
    m_hold     = 0;
    m_hold_cnt = 0;
    exp_q.delete();
    exp_hold_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One accepted sample. Entered and left at posedge+1 so calls chain back to back.
  task automatic strobe(input int s);
    bit last;
    int lv;
    sample_valid = 1'b1;
    sample       = s[SAMPLE_W-1:0];
    if (s > m_max) m_max = s;
    m_cnt = m_cnt + 1;
    last  = (m_cnt == WINDOW);
    if (last) begin
      lv = quant(m_max);
      if (lv >= m_hold) begin
        m_hold     = lv;
        m_hold_cnt = 0;
      end else if (m_hold_cnt == HOLD_WINDOWS - 1) begin
        m_hold     = (m_hold - 1 > lv) ? m_hold - 1 : lv;
        m_hold_cnt = 0;
      end else begin
        m_hold_cnt = m_hold_cnt + 1;
      end
      exp_q.push_back(LW'(lv));
      exp_hold_q.push_back(LW'(m_hold));
      m_cnt = 0;
      m_max = 0;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    if (last) begin
      total++;
      if (level_valid !== 1'b1) begin
        bad++;
        $display("FAIL latency: level_valid=%b required 1 one cycle after final strobe", level_valid);
      end
    end
  endtask

  task automatic window(input int s_rest, input int s_last);
    for (int i = 0; i < WINDOW - 1; i++) strobe(s_rest);
    strobe(s_last);
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (an === target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: an=%b never reached required %b", name, an, target);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && level_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_level_valid: level=%0d, required no pulse", level);
      end else begin
        logic [LW-1:0] e;
        logic [LW-1:0] h;
        e = exp_q.pop_front();
        h = exp_hold_q.pop_front();
        if (level !== e) begin
          bad++;
          $display("FAIL level: got %0d required %0d", level, e);
        end
        total++;
        if (hold_level !== h) begin
          bad++;
          $display("FAIL hold_level: got %0d required %0d", hold_level, h);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    hold_en      = 1'b0;
    model_reset();
    settle(2);
    total++; if (level !== 4'd0)        begin bad++; $display("FAIL rst_level: got %0d required 0", level); end
    total++; if (level_valid !== 1'b0)  begin bad++; $display("FAIL rst_level_valid: got %b required 0", level_valid); end
    total++; if (hold_level !== 4'd0)   begin bad++; $display("FAIL rst_hold: got %0d required 0", hold_level); end
    total++; if (led !== 16'h0001)      begin bad++; $display("FAIL rst_led: got %h required 0001", led); end
    total++; if (an !== 4'b1110)        begin bad++; $display("FAIL rst_an: got %b required 1110", an); end
    total++; if (seg !== 7'b1000000)    begin bad++; $display("FAIL rst_seg: got %b required 1000000", seg); end
    total++; if (dp !== 1'b1)           begin bad++; $display("FAIL rst_dp: got %b required 1", dp); end
    reset = 1'b0;
  endtask

  task automatic test_quiet();
    window(2048, 2048);
    settle(2);
    total++; if (led !== 16'h0001) begin bad++; $display("FAIL quiet_led: got %h required 0001", led); end
    wait_an(4'b1101, "quiet_an_tens");
    total++; if (seg !== 7'b1111111) begin bad++; $display("FAIL quiet_tens_blank: got %b required 1111111", seg); end
    wait_an(4'b1110, "quiet_an_units");
    total++; if (seg !== seg_of(0)) begin bad++; $display("FAIL quiet_units: got %b required %b", seg, seg_of(0)); end
  endtask

  task automatic test_mid_level();
    int n;
    window(2100, 3400);
    settle(2);
    total++; if (led !== 16'h07FF) begin bad++; $display("FAIL mid_led: got %h required 07FF", led); end
    wait_an(4'b1110, "mid_an_units");
    wait_an(4'b1101, "mid_an_tens");
    total++; if (seg !== 7'b1111001) begin bad++; $display("FAIL mid_tens: got %b required 1111001", seg); end
    n = 0;
    while (an === 4'b1101 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    total++; if (n != REFRESH_DIV) begin bad++; $display("FAIL slot_len: got %0d cycles required %0d", n, REFRESH_DIV); end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL mid_an_after: got %b required 1110", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL mid_units: got %b required 1000000", seg); end
  endtask

  task automatic test_clamp();
    window(4095, 4095);
    settle(2);
    total++; if (led !== 16'hFFFF) begin bad++; $display("FAIL clamp_led: got %h required FFFF", led); end
    window(1000, 1000);
    settle(2);
    total++; if (led !== 16'h0001) begin bad++; $display("FAIL low_led: got %h required 0001", led); end
  endtask

  task automatic test_hold();
    do_reset();
    hold_en = 1'b1;
    window(3584, 3584);
    settle(2);
    total++; if (led !== 16'h1FFF) begin bad++; $display("FAIL hold12_led: got %h required 1FFF", led); end
    wait_an(4'b1101, "hold_an_tens");
    total++; if (seg !== seg_of(1)) begin bad++; $display("FAIL hold_tens: got %b required %b", seg, seg_of(1)); end
    wait_an(4'b1110, "hold_an_units");
    total++; if (seg !== seg_of(2)) begin bad++; $display("FAIL hold_units: got %b required %b", seg, seg_of(2)); end
    for (int w = 0; w < 18; w++) begin
      if (w == 5) begin
        // Display flips to live level mid-window; hold state must be untouched.
        for (int i = 0; i < 4; i++) strobe(2432);
        hold_en = 1'b0;
        settle(2);
        total++; if (led !== 16'h000F) begin bad++; $display("FAIL live_led: got %h required 000F", led); end
        hold_en = 1'b1;
        for (int i = 0; i < 4; i++) strobe(2432);
      end else begin
        window(2432, 2432);
      end
      settle(2);
      total++;
      if (led !== therm(m_hold)) begin
        bad++;
        $display("FAIL hold_led w%0d: got %h required %h", w, led, therm(m_hold));
      end
    end
    total++; if (hold_level !== 4'd3) begin bad++; $display("FAIL hold_final: got %0d required 3", hold_level); end
    hold_en = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 5; i++) strobe(4095);
    do_reset();
    window(2048, 2048);
    settle(2);
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rstmid_level: got %0d required 0", level); end
  endtask

  task automatic test_reset_collision();
    reset        = 1'b1;
    sample_valid = 1'b1;
    sample       = 12'd4095;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    sample_valid = 1'b0;
    model_reset();
    window(2048, 2048);
    settle(2);
    total++; if (level !== 4'd0) begin bad++; $display("FAIL collide_level: got %0d required 0", level); end
    total++; if (led !== 16'h0001) begin bad++; $display("FAIL collide_led: got %h required 0001", led); end
  endtask

  task automatic test_back_to_back();
    // Two windows with no idle cycle between them.
    window(2048, 2048 + 5 * 128);
    window(2048 + 9 * 128, 2048);
    settle(2);
    total++; if (led !== therm(9)) begin bad++; $display("FAIL b2b_led: got %h required %h", led, therm(9)); end
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_mid_level();
    test_clamp();
    test_hold();
    test_reset_mid_window();
    test_reset_collision();
    test_back_to_back();
    settle(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected windows never reported, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
